// File: rtl/ddr_writer_pkg.sv
// Shared definitions for the DDR burst writer: FSM state encoding,
// data-pattern mode constants and the word counter width.
package ddr_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_GO        = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    // Data pattern selection
    localparam int unsigned MODE_CONST = 0;  // every word equals SEED
    localparam int unsigned MODE_INCR  = 1;  // SEED + running word count

    // Word counter wide enough for BURST_LEN up to 256
    localparam int unsigned CNT_W = 9;

endpackage

// File: rtl/but_sync_edge.sv
// Two-flop synchroniser for an asynchronous push-button plus a rising-edge
// detector on the synchronised level.
//   clk      in  clock
//   reset    in  synchronous active-high reset
//   async_in in  asynchronous level input
//   rise_c   out one-cycle pulse on a synchronised 0->1 transition
module but_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_c
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Shift chain: metastability stage, synchronised level, previous level
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/ddr_burst_writer.sv
// Button-triggered burst writer feeding a DDR write master: fills BURST_LEN
// words into the master buffer, pulses go, waits for done, then advances the
// burst address inside a wrapping window.
//   clk, reset                      clock, synchronous active-high reset
//   but0                            asynchronous start request
//   master_crtl_done                write master burst complete
//   master_user_buffer_full         write master buffer back-pressure
//   master_crtl_fixed_location      constant 0
//   master_crtl_write_base          current burst byte address
//   master_crtl_lenght              burst byte count
//   master_crtl_go                  one-cycle burst start pulse
//   master_user_write_buffer        buffer write strobe (combinational on full)
//   master_user_buffer_input_data   buffer write data
//   busy, led                       high whenever not idle
//   bursts_done                     completed-burst counter
module ddr_burst_writer #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned BURST_LEN    = 4,
    parameter logic [63:0] BASE_ADDR    = 64'h1000_0000,
    parameter int unsigned REGION_BYTES = 4096,
    parameter int unsigned MODE         = 0,
    parameter int unsigned SEED         = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              but0,
    input  logic              master_crtl_done,
    input  logic              master_user_buffer_full,
    output logic              master_crtl_fixed_location,
    output logic [ADDR_W-1:0] master_crtl_write_base,
    output logic [ADDR_W-1:0] master_crtl_lenght,
    output logic              master_crtl_go,
    output logic              master_user_write_buffer,
    output logic [DATA_W-1:0] master_user_buffer_input_data,
    output logic              busy,
    output logic [15:0]       bursts_done,
    output logic              led
);

    import ddr_writer_pkg::*;

    localparam int unsigned       BURST_BYTES = BURST_LEN * DATA_W / 8;
    localparam logic [ADDR_W-1:0] BURST_A     = ADDR_W'(BURST_BYTES);
    localparam logic [ADDR_W-1:0] BASE_A      = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] END_A       = BASE_A + ADDR_W'(REGION_BYTES);
    localparam logic [DATA_W-1:0] SEED_D      = DATA_W'(SEED);
    localparam logic [CNT_W-1:0]  LAST_WORD   = CNT_W'(BURST_LEN - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [15:0]         bursts_q, bursts_d;

    logic                start_c;
    logic                go_c;
    logic                wr_c;
    logic                busy_c;
    logic [ADDR_W-1:0]   base_sum_c;

    but_sync_edge u_but_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (but0),
        .rise_c   (start_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start_c || pend_q) state_d = ST_FILL;
            ST_FILL:      if (wr_c && (cnt_q == LAST_WORD)) state_d = ST_GO;
            ST_GO:        state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (master_crtl_done) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs; the write strobe follows buffer-full directly
    always_comb begin
        go_c   = 1'b0;
        wr_c   = 1'b0;
        busy_c = 1'b1;
        case (state_q)
            ST_IDLE: busy_c = 1'b0;
            ST_FILL: wr_c   = ~master_user_buffer_full;
            ST_GO:   go_c   = 1'b1;
            default: ;
        endcase
    end

    // Address advance with wrap back to the window base
    always_comb begin
        base_sum_c = base_q + BURST_A;
        if (base_sum_c == END_A) begin
            base_sum_c = BASE_A;
        end
    end

    // Datapath next values
    always_comb begin
        base_d   = base_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        bursts_d = bursts_q;
        // Pending survives only while busy; it is consumed by leaving IDLE
        pend_d   = busy_c ? (pend_q | start_c) : 1'b0;

        if (wr_c) begin
            cnt_d = (cnt_q == LAST_WORD) ? '0 : cnt_q + CNT_W'(1);
            if (MODE == MODE_INCR) begin
                data_d = data_q + DATA_W'(1);
            end
        end

        if ((state_q == ST_WAIT_DONE) && master_crtl_done) begin
            base_d   = base_sum_c;
            bursts_d = bursts_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q   <= BASE_A;
            data_q   <= SEED_D;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            bursts_q <= '0;
        end else begin
            base_q   <= base_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            bursts_q <= bursts_d;
        end
    end

    assign master_crtl_fixed_location    = 1'b0;
    assign master_crtl_write_base        = base_q;
    assign master_crtl_lenght            = BURST_A;
    assign master_crtl_go                = go_c;
    assign master_user_write_buffer      = wr_c;
    assign master_user_buffer_input_data = data_q;
    assign busy                          = busy_c;
    assign led                           = busy_c;
    assign bursts_done                   = bursts_q;

endmodule

// File: tb/tb_ddr_burst_writer.sv
// Self-checking bench: two writer instances (constant pattern / 4 KiB window,
// incrementing pattern / 32-byte window) share all inputs and are compared
// against a transaction-level reference model.
module tb_ddr_burst_writer;

    localparam int unsigned BL    = 4;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] BYTES = 32'd16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, but0, done, full;

    logic        fixed0, go0, wr0, busy0, led0;
    logic [31:0] base0, len0, data0;
    logic [15:0] bd0;
    logic        fixed1, go1, wr1, busy1, led1;
    logic [31:0] base1, len1, data1;
    logic [15:0] bd1;

    ddr_burst_writer dut0 (
        .clk(clk), .reset(reset), .but0(but0),
        .master_crtl_done(done), .master_user_buffer_full(full),
        .master_crtl_fixed_location(fixed0), .master_crtl_write_base(base0),
        .master_crtl_lenght(len0), .master_crtl_go(go0),
        .master_user_write_buffer(wr0), .master_user_buffer_input_data(data0),
        .busy(busy0), .bursts_done(bd0), .led(led0)
    );

    ddr_burst_writer #(.MODE(1), .SEED(0), .REGION_BYTES(32)) dut1 (
        .clk(clk), .reset(reset), .but0(but0),
        .master_crtl_done(done), .master_user_buffer_full(full),
        .master_crtl_fixed_location(fixed1), .master_crtl_write_base(base1),
        .master_crtl_lenght(len1), .master_crtl_go(go1),
        .master_user_write_buffer(wr1), .master_user_buffer_input_data(data1),
        .busy(busy1), .bursts_done(bd1), .led(led1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int unsigned m_words;        // words accepted since reset
    logic [31:0] m_base0, m_base1;
    logic [15:0] m_bursts;
    int          words;          // words accepted in the current burst

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] next_base(input logic [31:0] b, input logic [31:0] region);
        logic [31:0] n;
        n = b + BYTES;
        if (n >= BASE + region) n = BASE;
        return n;
    endfunction

    function automatic logic pick_full(input int mode, input int k);
        if (mode == 1) return (k >= 1 && k <= 3);
        if (mode == 2) return ($urandom_range(0, 2) == 0);
        return 1'b0;
    endfunction

    // One sampled FILL cycle: strobe mirrors ~full, accepted words carry the pattern
    task automatic fill_cycle();
        chk("fill_busy", busy0, 1'b1);
        chk("fill_go", go0 | go1, 1'b0);
        chk("strobe0", wr0, !full);
        chk("strobe1", wr1, !full);
        if (!full) begin
            chk("data0", data0, 32'd13);
            chk("data1", data1, 32'(m_words));
            m_words++;
            words++;
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            chk("idle_busy", busy0 | busy1, 1'b0);
            chk("idle_go", go0 | go1, 1'b0);
            chk("idle_strobe", wr0 | wr1, 1'b0);
            advance();
        end
    endtask

    // start_kind: 0 = button pulse, 1 = pending from previous burst
    // wait_kind:  0 = plain, 1 = button during WAIT_DONE, 2 = button edge with done
    task automatic do_burst(input int start_kind, input int full_mode, input int wait_kind);
        bit seen;
        int k, d;
        words = 0;
        seen  = 1'b0;
        full  = 1'b0;
        if (start_kind == 0) begin
            but0 = 1'b1;
            for (int c = 0; c < 10 && !seen; c++) begin
                if (c == 2) but0 = 1'b0;
                sample();
                if (busy0) seen = 1'b1;
                else advance();
            end
            but0 = 1'b0;
            if (!seen) begin
                chk("start_timeout", busy0, 1'b1);
                return;
            end
        end else begin
            sample();
            chk("pending_start", busy0, 1'b1);
        end

        k = 0;
        do begin
            if (k > 0) begin
                full = pick_full(full_mode, k);
                sample();
            end
            fill_cycle();
            advance();
            k++;
        end while (words < int'(BL) && k < 100);
        chk("fill_words", 32'(words), 32'(BL));

        full = 1'b0;
        sample();
        chk("go0", go0, 1'b1);
        chk("go1", go1, 1'b1);
        chk("go_strobe", wr0, 1'b0);
        chk("go_base0", base0, m_base0);
        chk("go_base1", base1, m_base1);
        chk("len0", len0, BYTES);
        chk("len1", len1, BYTES);
        chk("fixed", fixed0 | fixed1, 1'b0);
        chk("led", led0 & led1, 1'b1);
        advance();

        d = (wait_kind == 1) ? 5 : (wait_kind == 2) ? 2 : int'($urandom_range(0, 4));
        for (int i = 0; i < d; i++) begin
            but0 = (wait_kind != 0) && (i < 2);
            sample();
            chk("wait_go", go0, 1'b0);
            chk("wait_busy", busy0, 1'b1);
            chk("wait_base0", base0, m_base0);
            chk("wait_base1", base1, m_base1);
            advance();
        end
        but0 = 1'b0;
        done = 1'b1;
        sample();
        chk("done_busy", busy0, 1'b1);
        advance();
        done = 1'b0;
        m_base0  = next_base(m_base0, 32'd4096);
        m_base1  = next_base(m_base1, 32'd32);
        m_bursts = m_bursts + 16'd1;
        sample();
        chk("after_busy", busy0 | led0 | busy1, 1'b0);
        chk("after_base0", base0, m_base0);
        chk("after_base1", base1, m_base1);
        chk("bursts0", bd0, m_bursts);
        chk("bursts1", bd1, m_bursts);
        advance();
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_busy"}, busy0 | busy1 | led0 | led1, 1'b0);
        chk({tag, "_go"}, go0 | go1, 1'b0);
        chk({tag, "_strobe"}, wr0 | wr1, 1'b0);
        chk({tag, "_base0"}, base0, BASE);
        chk({tag, "_base1"}, base1, BASE);
        chk({tag, "_data0"}, data0, 32'd13);
        chk({tag, "_data1"}, data1, 32'd0);
        chk({tag, "_bd"}, {bd0, bd1}, 32'd0);
    endtask

    task automatic model_reset();
        m_words  = 0;
        m_base0  = BASE;
        m_base1  = BASE;
        m_bursts = '0;
    endtask

    initial begin
        reset = 1'b1; but0 = 1'b0; done = 1'b0; full = 1'b0;
        model_reset();
        advance();
        advance();
        sample();
        reset_check("reset");
        advance();
        reset = 1'b0;

        // done while idle must be ignored
        done = 1'b1;
        idle_check(2);
        done = 1'b0;
        sample();
        chk("idle_done_bd", bd0, 16'd0);
        advance();

        do_burst(0, 0, 0);      // basic burst
        idle_check(2);
        do_burst(0, 1, 0);      // back-pressure in fill cycles 2-4
        idle_check(2);
        do_burst(0, 2, 0);      // third burst: narrow window wraps
        idle_check(2);

        do_burst(0, 2, 1);      // button during WAIT_DONE
        do_burst(1, 2, 0);
        idle_check(4);
        do_burst(0, 0, 2);      // button edge coincident with done
        do_burst(1, 0, 0);
        idle_check(4);

        // reset after two accepted words abandons the burst
        words = 0;
        but0 = 1'b1;
        for (int c = 0; c < 10 && !busy0; c++) begin
            if (c == 2) but0 = 1'b0;
            advance();
        end
        but0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            fill_cycle();
            advance();
        end
        full  = 1'b1;
        reset = 1'b1;
        advance();
        reset = 1'b0;
        full  = 1'b0;
        model_reset();
        sample();
        reset_check("midreset");
        advance();
        idle_check(3);
        do_burst(0, 0, 0);
        idle_check(2);

        for (int r = 0; r < 6; r++) begin
            do_burst(0, 2, 0);
            idle_check(int'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ddr_burst_writer.md
DDR_BURST_WRITER -- requirements
Module: ddr_burst_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of the write base address.
REQ-002 SHALL have parameter DATA_W, default 32, word width (multiple of 8).
REQ-003 SHALL have parameter BURST_LEN, default 4, words per burst (1..256).
REQ-004 SHALL have parameter BASE_ADDR, default 'h10000000, first burst byte address.
REQ-005 SHALL have parameter REGION_BYTES, default 4096, size of the address window (multiple of the burst byte count).
REQ-006 SHALL have parameter MODE, default 0, data pattern: 0 = constant SEED, 1 = incrementing word counter.
REQ-007 SHALL have parameter SEED, default 13, constant or start value of the data pattern.
REQ-008 One clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-009 reset  in  1  synchronous active-high reset.
REQ-010 but0  in  1  asynchronous start request, active high.
REQ-011 master_crtl_done  in  1  write master burst complete.
REQ-012 master_user_buffer_full  in  1  write master buffer cannot accept data.
REQ-013 master_crtl_fixed_location  out  1  constant 0.
REQ-014 master_crtl_write_base  out  ADDR_W  current burst byte address.
REQ-015 master_crtl_lenght  out  ADDR_W  burst byte count = BURST_LEN*DATA_W/8.
REQ-016 master_crtl_go  out  1  one-cycle burst start pulse.
REQ-017 master_user_write_buffer  out  1  buffer write strobe.
REQ-018 master_user_buffer_input_data  out  DATA_W  buffer write data.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 bursts_done  out  16  completed-burst counter, wraps at 2^16.
REQ-021 led  out  1  equals busy.

Function
REQ-022 but0 SHALL pass a 2-flop synchroniser; a start event is a synchronised 0->1 edge.
REQ-023 FSM states SHALL be IDLE, FILL, GO, WAIT_DONE.
REQ-024 IDLE->FILL on a start event or a set pending flag (flag cleared on the transition).
REQ-025 In FILL, master_user_write_buffer SHALL equal NOT master_user_buffer_full (combinational); a word is accepted on each cycle where the strobe is high.
REQ-026 Word counter SHALL advance per accepted word; FILL->GO in the cycle the BURST_LEN-th word is accepted.
REQ-027 GO SHALL assert master_crtl_go for exactly one cycle, then go to WAIT_DONE.
REQ-028 WAIT_DONE->IDLE on master_crtl_done=1; on the same edge write_base += burst byte count and bursts_done increments.
REQ-029 If the advanced address reaches BASE_ADDR+REGION_BYTES it SHALL wrap to BASE_ADDR.
REQ-030 MODE 0: data SHALL be SEED for every word; MODE 1: data SHALL be SEED+n, n = total words accepted since reset, modulo 2^DATA_W, continuing across bursts.
REQ-031 A start event while busy SHALL set a single pending flag (further events ignored until it clears); a start event coincident with done SHALL set the flag.
REQ-032 master_crtl_done outside WAIT_DONE SHALL be ignored.
REQ-033 write_base SHALL be stable from GO until leaving WAIT_DONE.

Reset
REQ-034 On reset: state IDLE, write_base BASE_ADDR, go 0, write strobe 0, data SEED, pending 0, word counter 0, bursts_done 0, synchroniser 0, led 0.
REQ-035 Reset mid-burst SHALL abandon the burst without a go pulse; next burst restarts at BASE_ADDR.

Structure
REQ-036 Package ddr_writer_pkg SHALL hold the state encoding and MODE constants.
REQ-037 Sub-module but_sync_edge SHALL implement the synchroniser and rising-edge detector.

Verification
REQ-038 Defaults, one but0 pulse, full=0 -> 4 strobes of 13 in consecutive cycles, go one cycle later, base 'h10000000, lenght 16; done -> base 'h10000010, bursts_done 1.
REQ-039 full high for cycles 2-4 of FILL -> exactly 4 accepted words, no strobe while full, go only after 4th.
REQ-040 MODE 1, SEED 0, two bursts -> data 0..3 then 4..7.
REQ-041 REGION_BYTES 32, three bursts -> bases 'h10000000, 'h10000010, 'h10000000.
REQ-042 but0 pulse during WAIT_DONE and pulse coincident with done -> exactly one extra burst each, starting immediately after IDLE.
REQ-043 reset asserted after 2 accepted words -> no go, outputs at reset values, next burst at BASE_ADDR with 4 words.
